// File: rtl/vec_pkg.sv
// Shared line-segment types for the vector core, the line FIFO and the rasteriser.
package vec_pkg;

  localparam int VEC_COORD_W = 13;
  localparam int VEC_INT_W   = 4;

  typedef struct packed {
    logic [VEC_COORD_W-1:0] start_x;
    logic [VEC_COORD_W-1:0] end_x;
    logic [VEC_COORD_W-1:0] start_y;
    logic [VEC_COORD_W-1:0] end_y;
    logic [VEC_INT_W-1:0]   intensity;
  } line_t;

endpackage

// File: rtl/vec_line_fifo_mem.sv
// Line FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module vec_line_fifo_mem
  import vec_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 4 * VEC_COORD_W + VEC_INT_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vec_line_fifo.sv
// First-word fall-through FIFO of line segments with flush, almost-full and sticky error flags.
// Optional macro VEC_LINE_FIFO_WR_EDGE_EN: write only on the rising edge of wr.
module vec_line_fifo
  import vec_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int COORD_W  = VEC_COORD_W,
  parameter int INT_W    = VEC_INT_W,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr,
  input  logic [COORD_W-1:0] d_start_x,
  input  logic [COORD_W-1:0] d_end_x,
  input  logic [COORD_W-1:0] d_start_y,
  input  logic [COORD_W-1:0] d_end_y,
  input  logic [INT_W-1:0]   d_intensity,
  input  logic               rd,
  output logic [COORD_W-1:0] q_start_x,
  output logic [COORD_W-1:0] q_end_x,
  output logic [COORD_W-1:0] q_start_y,
  output logic [COORD_W-1:0] q_end_y,
  output logic [INT_W-1:0]   q_intensity,
  output logic               empty,
  output logic               full,
  output logic               almost_full,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic               underflow
);

  localparam int EW = 4 * COORD_W + INT_W;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);

  logic [AW-1:0] wp, rp;
  logic          we, re, wa;
  logic [EW-1:0] wdata, rdata;

`ifdef VEC_LINE_FIFO_WR_EDGE_EN
  // The core holds its strobe for several clocks; only the first high cycle counts.
  logic wr_q;
  always_ff @(posedge clk) begin
    if (rst || flush) wr_q <= 1'b0;
    else              wr_q <= wr;
  end
  assign we = wr && !wr_q;
`else
  assign we = wr;
`endif

  assign empty       = (count == '0);
  assign full        = (count == C_DEPTH);
  assign almost_full = (count >= C_AF);

  assign re = rd && !empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign wa = we && (!full || re) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wa) wp <= wp + AW'(1);
      if (re) rp <= rp + AW'(1);
      case ({wa, re})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (we && full && !rd) overflow  <= 1'b1;
      if (rd && empty)       underflow <= 1'b1;
    end
  end

  assign wdata = {d_start_x, d_end_x, d_start_y, d_end_y, d_intensity};

  vec_line_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .wen   (wa && !rst),
    .waddr (wp),
    .wdata (wdata),
    .raddr (rp),
    .rdata (rdata)
  );

  assign {q_start_x, q_end_x, q_start_y, q_end_y, q_intensity} = rdata;

endmodule
